// File: rtl/videobox_led_ctrl.sv
// Avalon-MM LED/GPIO output controller: static data, atomic set/clear and per-channel blink.
// Registered read data with one-cycle latency, no wait states.
module videobox_led_ctrl #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE   = 50000,
  parameter int PERIOD_RST = 500
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic             read_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_MODE   = 3'd1;
  localparam logic [2:0] A_PERIOD = 3'd2;
  localparam logic [2:0] A_SET    = 3'd3;
  localparam logic [2:0] A_CLR    = 3'd4;
  localparam logic [2:0] A_STATUS = 3'd5;

  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] mode_reg;
  logic [15:0]      period_reg;
  logic [PW-1:0]    pre_cnt;
  logic [15:0]      ph_cnt;
  logic             blink_phase;

  logic             wr_en;
  logic             rd_en;
  logic             tick;
  logic [15:0]      ph_last;
  logic [WIDTH-1:0] wdata;
  logic [31:0]      rd_mux;

  assign wr_en = chipselect & ~write_n;
  assign rd_en = chipselect & ~read_n;
  assign tick  = (pre_cnt == PRE_MAX);
  assign wdata = writedata[WIDTH-1:0];
  // PERIOD=0 is treated as a half-period of one tick
  assign ph_last = (period_reg == 16'd0) ? 16'd0 : period_reg - 16'd1;

  always_comb begin
    rd_mux = 32'd0;
    case (address)
      A_DATA:   rd_mux = 32'(data_reg);
      A_MODE:   rd_mux = 32'(mode_reg);
      A_PERIOD: rd_mux = {16'd0, period_reg};
      A_STATUS: rd_mux = {ph_cnt, 15'd0, blink_phase};
      default:  rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_reg    <= '0;
      mode_reg    <= '0;
      period_reg  <= 16'(PERIOD_RST);
      pre_cnt     <= '0;
      ph_cnt      <= 16'd0;
      blink_phase <= 1'b1;
      out_port    <= '0;
      readdata    <= 32'd0;
    end else begin
      out_port <= data_reg & (~mode_reg | {WIDTH{blink_phase}});

      // read mux sees pre-write state, so a coincident write is not visible yet
      if (rd_en) readdata <= rd_mux;

      if (wr_en) begin
        case (address)
          A_DATA:   data_reg   <= wdata;
          A_MODE:   mode_reg   <= wdata;
          A_PERIOD: period_reg <= writedata[15:0];
          A_SET:    data_reg   <= data_reg | wdata;
          A_CLR:    data_reg   <= data_reg & ~wdata;
          default:  ;
        endcase
      end

      // a PERIOD write restarts the blink timebase and overrides any tick
      if (wr_en && address == A_PERIOD) begin
        pre_cnt     <= '0;
        ph_cnt      <= 16'd0;
        blink_phase <= 1'b1;
      end else if (tick) begin
        pre_cnt <= '0;
        if (ph_cnt == ph_last) begin
          ph_cnt      <= 16'd0;
          blink_phase <= ~blink_phase;
        end else begin
          ph_cnt <= ph_cnt + 16'd1;
        end
      end else begin
        pre_cnt <= pre_cnt + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_videobox_led_ctrl.sv
// Bench for videobox_led_ctrl: directed scenarios plus random bus traffic against an
// elapsed-time model of the blink timebase.
module tb_videobox_led_ctrl;

  localparam int W  = 8;
  localparam int PS = 4;
  localparam int PR = 500;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [W-1:0] out_port;

  int n_checks = 0;
  int n_errors = 0;

  // model: registers plus cycles elapsed since the last timebase restart
  logic [W-1:0] m_data, m_mode, m_out;
  logic [15:0]  m_period;
  logic [31:0]  m_rd;
  int           m_el;

  videobox_led_ctrl #(.WIDTH(W), .PRESCALE(PS), .PERIOD_RST(PR)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata),
    .readdata(readdata), .out_port(out_port)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int eff_period(input logic [15:0] p);
    return (p == 16'd0) ? 1 : int'(p);
  endfunction

  function automatic logic m_phase(input int el, input logic [15:0] p);
    return ((el / (PS * eff_period(p))) % 2) == 0;
  endfunction

  function automatic logic [15:0] m_cnt(input int el, input logic [15:0] p);
    return 16'((el / PS) % eff_period(p));
  endfunction

  task automatic m_reset();
    m_data = '0; m_mode = '0; m_period = 16'(PR); m_el = 0; m_out = '0; m_rd = 32'd0;
  endtask

  task automatic cyc(input logic cs, input logic wn, input logic rn, input logic [2:0] a,
                     input logic [31:0] wd, input logic rstn);
    logic ph;
    logic anchor;
    reset_n = rstn; chipselect = cs; write_n = wn; read_n = rn; address = a; writedata = wd;
    @(posedge clk);
    if (!rstn) begin
      m_reset();
    end else begin
      ph = m_phase(m_el, m_period);
      anchor = 1'b0;
      if (cs && !rn) begin
        case (a)
          3'd0: m_rd = {24'd0, m_data};
          3'd1: m_rd = {24'd0, m_mode};
          3'd2: m_rd = {16'd0, m_period};
          3'd5: m_rd = {m_cnt(m_el, m_period), 15'd0, ph};
          default: m_rd = 32'd0;
        endcase
      end
      m_out = ph ? m_data : (m_data & ~m_mode);
      if (cs && !wn) begin
        case (a)
          3'd0: m_data = wd[W-1:0];
          3'd1: m_mode = wd[W-1:0];
          3'd2: begin m_period = wd[15:0]; anchor = 1'b1; end
          3'd3: m_data = m_data | wd[W-1:0];
          3'd4: m_data = m_data & ~wd[W-1:0];
          default: ;
        endcase
      end
      m_el = anchor ? 0 : m_el + 1;
    end
    #1;
    chk("out_port", {24'd0, out_port}, {24'd0, m_out});
    chk("readdata", readdata, m_rd);
  endtask

  task automatic idle();              cyc(1'b0, 1'b1, 1'b1, 3'd0, 32'd0, 1'b1); endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d); cyc(1'b1, 1'b0, 1'b1, a, d, 1'b1); endtask
  task automatic rd(input logic [2:0] a); cyc(1'b1, 1'b1, 1'b0, a, 32'd0, 1'b1); endtask

  // idles until out_port equals target; returns the cycle count or -1 on timeout
  task automatic wait_out(input logic [W-1:0] target, output int n);
    n = -1;
    for (int k = 1; k <= 200; k++) begin
      idle();
      if (out_port === target) begin n = k; break; end
    end
  endtask

  initial begin
    int n;
    logic [31:0] v;
    m_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 3'd0, 32'd0, 1'b0);

    // reset values
    rd(3'd0); chk("rst_data", readdata, 32'h0);
    rd(3'd1); chk("rst_mode", readdata, 32'h0);
    rd(3'd2); chk("rst_period", readdata, 32'd500);
    rd(3'd5); chk("rst_status", readdata, 32'h1);
    chk("rst_out", {24'd0, out_port}, 32'h0);

    // set/clear
    wr(3'd0, 32'h0F); wr(3'd3, 32'hF0); wr(3'd4, 32'h81);
    idle(); chk("clr_out", {24'd0, out_port}, 32'h7E);
    rd(3'd0); chk("setclr_data", readdata, 32'h7E);
    wr(3'd3, 32'hFFFF_FF00); rd(3'd0); chk("set_upper", readdata, 32'h7E);

    // blink
    wr(3'd0, 32'hFF); wr(3'd1, 32'h0F); wr(3'd2, 32'd3);
    wait_out(8'hF0, n); chk("first_toggle", n, 13);
    wait_out(8'hFF, n); chk("half_period", n, 12);
    wait_out(8'hF0, n); chk("half_period2", n, 12);

    // PERIOD=0 behaves as 1
    wr(3'd2, 32'd0);
    wait_out(8'hF0, n); chk("p0_first", n, 5);
    wait_out(8'hFF, n); chk("p0_half", n, 4);

    // rewrite PERIOD on the edge of a scheduled toggle
    wr(3'd2, 32'd1);
    for (int i = 0; i < 3; i++) idle();
    wr(3'd2, 32'd1);
    rd(3'd5); chk("suppress_status", readdata, 32'h1);
    chk("suppress_out", {24'd0, out_port}, 32'hFF);

    // simultaneous read and write
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 32'h5A, 1'b1); chk("rw_old", readdata, 32'hFF);
    rd(3'd0); chk("rw_new", readdata, 32'h5A);

    // reserved write
    wr(3'd7, 32'hFFFF_FFFF); rd(3'd0); chk("resv_data", readdata, 32'h5A);
    rd(3'd7); chk("resv_read", readdata, 32'h0);
    rd(3'd3); chk("set_read", readdata, 32'h0);

    // reset during blink phase 0
    wr(3'd0, 32'hFF); wr(3'd2, 32'd3);
    wait_out(8'hF0, n); chk("pre_reset_toggle", n, 13);
    cyc(1'b0, 1'b1, 1'b1, 3'd0, 32'd0, 1'b0);
    chk("mid_rst_out", {24'd0, out_port}, 32'h0);
    rd(3'd1); chk("mid_rst_mode", readdata, 32'h0);
    rd(3'd2); chk("mid_rst_period", readdata, 32'd500);
    rd(3'd5); v = readdata; chk("mid_rst_status", v & 32'h0000_0001, 32'h1);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      logic [2:0] a;
      logic [31:0] d;
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      if (a == 3'd2) d = $urandom_range(0, 5);
      if ($urandom_range(0, 499) == 0)
        cyc(1'b0, 1'b1, 1'b1, 3'd0, 32'd0, 1'b0);
      else
        cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), a, d, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
